// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector: Moore FSM tracking the matched-prefix
// length of PATTERN, with overlap selection and a saturating, clearable match counter.
module seq_detect_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
  localparam int            SW      = $clog2(N + 1)
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             en,
  input  logic             in,
  input  logic             clr_cnt,
  output logic             y,
  output logic [SW-1:0]    c,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [SW-1:0]    FULL    = SW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Longest prefix of PATTERN that is a suffix of (prefix of length k, then b).
  // Codes above N are unreachable in normal operation and map back to 0.
  function automatic logic [SW-1:0] delta_f(input int k, input logic b);
    int           kp;
    int           best;
    int           idx;
    logic         ok;
    logic         sb;
    logic [N-1:0] sh;
    best = 0;
    if (k <= N) begin
      kp = (k == N && !OVERLAP) ? 0 : k;
      for (int l = 1; l <= N; l++) begin
        if (l <= kp + 1) begin
          ok = 1'b1;
          for (int j = 0; j < l; j++) begin
            idx = kp + 1 - l + j;
            sh  = PATTERN >> (N - 1 - idx);
            sb  = (idx == kp) ? b : sh[0];
            sh  = PATTERN >> (N - 1 - j);
            if (sb != sh[0]) ok = 1'b0;
          end
          if (ok) best = l;
        end
      end
    end
    return SW'(best);
  endfunction

  logic [SW-1:0] tbl [2**SW][2];

  for (genvar k = 0; k < 2**SW; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam logic [SW-1:0] D = delta_f(k, b == 1);
      assign tbl[k][b] = D;
    end
  end

  logic [SW-1:0] c_nxt;
  logic          hit;

  always_comb begin
    c_nxt = c;
    hit   = 1'b0;
    // An illegal code steps through the table to 0 even while stalled.
    if (en || c > FULL) c_nxt = tbl[c][in];
    if (en && c_nxt == FULL) hit = 1'b1;
  end

  // NOTE: state and counter use non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge ck) begin
    if (rs) begin
      c         <= '0;
      match_cnt <= '0;
    end else begin
      c <= c_nxt;
      if (clr_cnt)                           match_cnt <= '0;
      else if (hit && match_cnt != CNT_MAX)  match_cnt <= match_cnt + 1'b1;
    end
  end

  assign y = (c == FULL);

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: three detector variants driven by one stream, compared every
// cycle against a history-based reference model, plus hand-computed directed checks.
module tb_seq_detect_param;

  localparam int         N   = 4;
  localparam logic [3:0] PAT = 4'b1011;

  logic       ck = 1'b0;
  logic       rs = 1'b1;
  logic       en = 1'b0;
  logic       bit_in = 1'b0;
  logic       clr = 1'b0;

  logic       y_ov, y_no, y_c2;
  logic [2:0] c_ov, c_no, c_c2;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_c2;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  started = 1'b0;

  always #5 ck = ~ck;

  seq_detect_param #(.N(N), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .ck(ck), .rs(rs), .en(en), .in(bit_in), .clr_cnt(clr),
    .y(y_ov), .c(c_ov), .match_cnt(cnt_ov));

  seq_detect_param #(.N(N), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .ck(ck), .rs(rs), .en(en), .in(bit_in), .clr_cnt(clr),
    .y(y_no), .c(c_no), .match_cnt(cnt_no));

  seq_detect_param #(.N(N), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
    .ck(ck), .rs(rs), .en(en), .in(bit_in), .clr_cnt(clr),
    .y(y_c2), .c(c_c2), .match_cnt(cnt_c2));

  // Reference: remember the recent sampled bits and derive the state as the
  // longest pattern prefix that ends the remembered history.
  typedef struct {
    logic [N-1:0] hist;
    int           hcnt;
    int           cnt;
  } model_t;

  model_t m_ov, m_no, m_c2;

  function automatic int prefix_len(input model_t m);
    int h;
    int p;
    h = int'(m.hist);
    p = int'(PAT);
    for (int k = N; k >= 1; k--)
      if (k <= m.hcnt && (h & ((1 << k) - 1)) == (p >> (N - k))) return k;
    return 0;
  endfunction

  function automatic model_t model_step(input model_t m, input bit ovl, input int cmax,
                                        input logic r, input logic e, input logic b,
                                        input logic cl);
    model_t n;
    n = m;
    if (r) begin
      n.hist = '0;
      n.hcnt = 0;
      n.cnt  = 0;
      return n;
    end
    if (e) begin
      if (!ovl && prefix_len(m) == N) n.hcnt = 0;
      n.hist = {n.hist[N-2:0], b};
      n.hcnt = (n.hcnt + 1 > N) ? N : n.hcnt + 1;
    end
    if (cl)                                           n.cnt = 0;
    else if (e && prefix_len(n) == N && n.cnt < cmax) n.cnt = n.cnt + 1;
    return n;
  endfunction

  always @(posedge ck) begin
    m_ov <= model_step(m_ov, 1'b1, 255, rs, en, bit_in, clr);
    m_no <= model_step(m_no, 1'b0, 255, rs, en, bit_in, clr);
    m_c2 <= model_step(m_c2, 1'b1, 3,   rs, en, bit_in, clr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ck) begin
    if (started) begin
      check("ov_c",   32'(c_ov),   32'(prefix_len(m_ov)));
      check("ov_y",   32'(y_ov),   32'(prefix_len(m_ov) == N));
      check("ov_cnt", 32'(cnt_ov), 32'(m_ov.cnt));
      check("no_c",   32'(c_no),   32'(prefix_len(m_no)));
      check("no_y",   32'(y_no),   32'(prefix_len(m_no) == N));
      check("no_cnt", 32'(cnt_no), 32'(m_no.cnt));
      check("c2_c",   32'(c_c2),   32'(prefix_len(m_c2)));
      check("c2_y",   32'(y_c2),   32'(prefix_len(m_c2) == N));
      check("c2_cnt", 32'(cnt_c2), 32'(m_c2.cnt));
    end
  end

  task automatic drive(input logic r, input logic e, input logic b, input logic cl);
    @(negedge ck);
    rs     = r;
    en     = e;
    bit_in = b;
    clr    = cl;
  endtask

  task automatic settle();
    @(posedge ck);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, bits[i], 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // T1: reset for two cycles, then 1011
    do_reset();
    settle();
    started = 1'b1;
    check("t1_rst_c",   32'(c_ov),   32'd0);
    check("t1_rst_y",   32'(y_ov),   32'd0);
    check("t1_rst_cnt", 32'(cnt_ov), 32'd0);
    do_reset();
    send_bits(16'b1011, 4);
    settle();
    check("t1_y",   32'(y_ov),   32'd1);
    check("t1_c",   32'(c_ov),   32'd4);
    check("t1_cnt", 32'(cnt_ov), 32'd1);
    send_bits(16'b0, 1);
    settle();
    check("t1_y_drop", 32'(y_ov), 32'd0);
    check("t1_c_next", 32'(c_ov), 32'd2);

    // T2: 1011011, overlapping vs non-overlapping
    do_reset();
    send_bits(16'b1011011, 7);
    settle();
    check("t2_ov_y",   32'(y_ov),   32'd1);
    check("t2_ov_cnt", 32'(cnt_ov), 32'd2);
    check("t2_no_y",   32'(y_no),   32'd0);
    check("t2_no_cnt", 32'(cnt_no), 32'd1);

    // T3: stall with toggling input between 10 and 11
    do_reset();
    send_bits(16'b10, 2);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'(i % 2 == 0), 1'b0);
    settle();
    check("t3_stall_c", 32'(c_ov), 32'd2);
    send_bits(16'b11, 2);
    settle();
    check("t3_y",   32'(y_ov),   32'd1);
    check("t3_cnt", 32'(cnt_ov), 32'd1);

    // T4: five back-to-back matches into a 2-bit counter
    do_reset();
    for (int j = 0; j < 5; j++) begin
      send_bits(16'b1011, 4);
      settle();
      check("t4_cnt", 32'(cnt_c2), 32'((j + 1 > 3) ? 3 : j + 1));
    end

    // T5: reset in mid-pattern discards the partial match
    do_reset();
    send_bits(16'b101, 3);
    do_reset();
    send_bits(16'b1, 1);
    settle();
    check("t5_c",   32'(c_ov),   32'd1);
    check("t5_y",   32'(y_ov),   32'd0);
    check("t5_cnt", 32'(cnt_ov), 32'd0);

    // T6: clear on the completing edge wins over the increment
    do_reset();
    send_bits(16'b101, 3);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    settle();
    check("t6_y",   32'(y_ov),   32'd1);
    check("t6_cnt", 32'(cnt_ov), 32'd0);
    send_bits(16'b011, 3);
    settle();
    check("t6_cnt_next", 32'(cnt_ov), 32'd1);

    // Random traffic with sparse stalls, clears and resets
    for (int i = 0; i < 4000; i++)
      drive(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),        1'($urandom_range(0, 79) == 0));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    @(negedge ck);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
